decode_issue: RTL and testbench

//  Decode/issue stage directly upstream of the 64x32 register file. Accepts a 32-bit

---
 rtl/decode_issue.sv | 116 +++++++++++
 tb/tb_decode_issue.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue.sv
// decode_issue: decode/issue stage in front of the register file.
// Decodes a 32-bit instruction, checks a pending-write scoreboard and issues
// at most one instruction per cycle into a registered output slot.
module decode_issue #(
  parameter int AW       = 6,
  parameter int IW       = 32,
  parameter int STALL_CW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IW-1:0]        in_instr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [5:0]           out_op,
  output logic [AW-1:0]        out_rd,
  output logic                 out_we,
  output logic [7:0]           out_imm,
  output logic [AW-1:0]        ra1,
  output logic [AW-1:0]        ra2,
  input  logic                 wb_valid,
  input  logic [AW-1:0]        wb_addr,
  output logic [(2**AW)-1:0]   busy_map,
  output logic [STALL_CW-1:0]  stall_cnt
);

  localparam int NR = 2**AW;

  logic [5:0]    op;
  logic [AW-1:0] rd;
  logic [AW-1:0] rs1;
  logic [AW-1:0] rs2;
  logic [7:0]    imm;
  logic          use1;
  logic          use2;
  logic          we_i;
  logic          hazard;
  logic          space;
  logic          issue;
  logic [NR-1:0] clr_mask;
  logic [NR-1:0] set_mask;
  logic [NR-1:0] busy_nxt;

  assign op  = in_instr[31:26];
  assign rd  = in_instr[20 +: AW];
  assign rs1 = in_instr[14 +: AW];
  assign rs2 = in_instr[8 +: AW];
  assign imm = in_instr[7:0];

  // Class decode from op[5:4] and hazard check against the registered scoreboard
  always_comb begin
    use1   = 1'b0;
    use2   = 1'b0;
    we_i   = 1'b0;
    case (op[5:4])
      2'b01: begin use1 = 1'b1; use2 = 1'b1; we_i = (rd != '0); end
      2'b10: begin use1 = 1'b1;              we_i = (rd != '0); end
      2'b11: begin use1 = 1'b1; use2 = 1'b1;                    end
      default: ;
    endcase
    hazard   = (use1 & busy_map[rs1]) | (use2 & busy_map[rs2]) | (we_i & busy_map[rd]);
    space    = !out_valid || out_ready;
    in_ready = space && !hazard;
    issue    = in_valid && in_ready;
  end

  // Scoreboard next state: clear on writeback first, then set on issue so set wins
  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (wb_valid) clr_mask[wb_addr] = 1'b1;
    if (issue && we_i) set_mask[rd] = 1'b1;
    busy_nxt    = (busy_map & ~clr_mask) | set_mask;
    busy_nxt[0] = 1'b0;
  end

  // Output register: load on issue, drop valid when consumed, hold under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_op    <= '0;
      out_rd    <= '0;
      out_we    <= 1'b0;
      out_imm   <= '0;
      ra1       <= '0;
      ra2       <= '0;
    end else if (issue) begin
      out_valid <= 1'b1;
      out_op    <= op;
      out_rd    <= rd;
      out_we    <= we_i;
      out_imm   <= imm;
      ra1       <= rs1;
      ra2       <= rs2;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Pending-write scoreboard
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_map <= '0;
    else        busy_map <= busy_nxt;
  end

  // Saturating count of cycles an offered instruction was held back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (in_valid && !in_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_issue.sv
// tb_decode_issue: directed vectors with hand-computed expectations.
module tb_decode_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_op;
  logic [5:0]  out_rd;
  logic        out_we;
  logic [7:0]  out_imm;
  logic [5:0]  ra1;
  logic [5:0]  ra2;
  logic        wb_valid;
  logic [5:0]  wb_addr;
  logic [63:0] busy_map;
  logic [15:0] stall_cnt;

  int nvec = 0;
  int nerr = 0;

  localparam logic [5:0] OP_NOP = 6'h05;
  localparam logic [5:0] OP_R   = 6'h10;
  localparam logic [5:0] OP_I   = 6'h20;
  localparam logic [5:0] OP_S   = 6'h30;

  decode_issue #(.AW(6), .IW(32), .STALL_CW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_rd(out_rd), .out_we(out_we), .out_imm(out_imm),
    .ra1(ra1), .ra2(ra2),
    .wb_valid(wb_valid), .wb_addr(wb_addr),
    .busy_map(busy_map), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [5:0] rd,
                                     input logic [5:0] rs1, input logic [5:0] rs2,
                                     input logic [7:0] imm);
    return {op, rd, rs1, rs2, imm};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_op"},    64'(out_op),    64'd0);
    chk({tag, "_rd"},    64'(out_rd),    64'd0);
    chk({tag, "_we"},    64'(out_we),    64'd0);
    chk({tag, "_imm"},   64'(out_imm),   64'd0);
    chk({tag, "_ra1"},   64'(ra1),       64'd0);
    chk({tag, "_ra2"},   64'(ra2),       64'd0);
    chk({tag, "_busy"},  busy_map,       64'd0);
    chk({tag, "_stall"}, 64'(stall_cnt), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
    wb_valid = 1'b0; wb_addr = '0;
    #12;
    chk_zero("rst0");
    rst_n = 1'b1;
    step();

    // back-to-back independent R then I
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = mk(OP_R, 6'd1, 6'd2, 6'd3, 8'h11);
    #1 chk("b2b_rdy0", 64'(in_ready), 64'd1);
    step();
    chk("b2b_v0",   64'(out_valid), 64'd1);
    chk("b2b_op0",  64'(out_op),    64'h10);
    chk("b2b_rd0",  64'(out_rd),    64'd1);
    chk("b2b_we0",  64'(out_we),    64'd1);
    chk("b2b_imm0", 64'(out_imm),   64'h11);
    chk("b2b_ra10", 64'(ra1),       64'd2);
    chk("b2b_ra20", 64'(ra2),       64'd3);
    in_instr = mk(OP_I, 6'd4, 6'd5, 6'd9, 8'h22);
    #1 chk("b2b_rdy1", 64'(in_ready), 64'd1);
    step();
    chk("b2b_v1",   64'(out_valid), 64'd1);
    chk("b2b_rd1",  64'(out_rd),    64'd4);
    chk("b2b_ra11", 64'(ra1),       64'd5);
    chk("b2b_ra21", 64'(ra2),       64'd9);
    chk("b2b_imm1", 64'(out_imm),   64'h22);
    chk("b2b_busy", busy_map,       64'h12);
    in_valid = 1'b0;
    step();
    chk("drain_v",   64'(out_valid), 64'd0);
    chk("drain_ra1", 64'(ra1),       64'd5);
    wb_valid = 1'b1; wb_addr = 6'd1;
    step();
    chk("wb1_busy", busy_map, 64'h10);
    wb_addr = 6'd4;
    step();
    chk("wb4_busy", busy_map, 64'h0);
    wb_valid = 1'b0;

    // RAW stall released by writeback, no same-cycle bypass
    in_valid = 1'b1; in_instr = mk(OP_R, 6'd1, 6'd7, 6'd8, 8'h00);
    step();
    chk("raw_busy0", busy_map, 64'h2);
    in_instr = mk(OP_R, 6'd6, 6'd1, 6'd2, 8'h44);
    for (int i = 0; i < 3; i++) begin
      #1 chk("raw_rdy_stall", 64'(in_ready), 64'd0);
      step();
    end
    chk("raw_stall3", 64'(stall_cnt), 64'd3);
    wb_valid = 1'b1; wb_addr = 6'd1;
    #1 chk("raw_nobypass", 64'(in_ready), 64'd0);
    step();
    wb_valid = 1'b0;
    chk("raw_busy_clr", busy_map, 64'h0);
    #1 chk("raw_rdy_rel", 64'(in_ready), 64'd1);
    step();
    chk("raw_v",     64'(out_valid), 64'd1);
    chk("raw_rd",    64'(out_rd),    64'd6);
    chk("raw_ra1",   64'(ra1),       64'd1);
    chk("raw_ra2",   64'(ra2),       64'd2);
    chk("raw_stall", 64'(stall_cnt), 64'd4);
    chk("raw_busy6", busy_map,       64'h40);
    in_valid = 1'b0; wb_valid = 1'b1; wb_addr = 6'd6;
    step();
    wb_valid = 1'b0;
    chk("raw_busy_end", busy_map, 64'h0);

    // backpressure: S held while R waits
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = mk(OP_S, 6'd9, 6'd10, 6'd11, 8'h33);
    #1 chk("bp_rdy0", 64'(in_ready), 64'd1);
    step();
    chk("bp_we",  64'(out_we), 64'd0);
    chk("bp_rd",  64'(out_rd), 64'd9);
    in_instr = mk(OP_R, 6'd12, 6'd13, 6'd14, 8'h55);
    for (int i = 0; i < 5; i++) begin
      #1 chk("bp_rdy", 64'(in_ready), 64'd0);
      step();
      chk("bp_v",    64'(out_valid), 64'd1);
      chk("bp_ra1",  64'(ra1),       64'd10);
      chk("bp_ra2",  64'(ra2),       64'd11);
      chk("bp_imm",  64'(out_imm),   64'h33);
      chk("bp_busy", busy_map,       64'h0);
    end
    chk("bp_stall", 64'(stall_cnt), 64'd9);
    out_ready = 1'b1;
    #1 chk("bp_rdy_rel", 64'(in_ready), 64'd1);
    step();
    chk("bp_rd2",    64'(out_rd),    64'd12);
    chk("bp_ra12",   64'(ra1),       64'd13);
    chk("bp_busy2",  busy_map,       64'h1000);
    chk("bp_stall2", 64'(stall_cnt), 64'd9);

    // set/clear collision and benign writebacks
    in_instr = mk(OP_I, 6'd7, 6'd0, 6'd0, 8'h01);
    wb_valid = 1'b1; wb_addr = 6'd7;
    #1 chk("col_rdy", 64'(in_ready), 64'd1);
    step();
    chk("col_busy", busy_map, 64'h1080);
    in_valid = 1'b0; wb_addr = 6'd0;
    step();
    chk("wb0_busy", busy_map, 64'h1080);
    wb_addr = 6'd5;
    step();
    chk("wbidle_busy", busy_map, 64'h1080);
    wb_addr = 6'd12;
    step();
    chk("wb12_busy", busy_map, 64'h80);
    wb_addr = 6'd7;
    step();
    chk("wb7_busy", busy_map, 64'h0);
    wb_valid = 1'b0;

    // asynchronous reset mid-operation
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = mk(OP_R, 6'd3, 6'd1, 6'd2, 8'h77);
    step();
    in_valid = 1'b0;
    chk("pre_rst_v",    64'(out_valid), 64'd1);
    chk("pre_rst_busy", busy_map,       64'h8);
    #2 rst_n = 1'b0;
    #1 chk_zero("rst1");
    rst_n = 1'b1;
    step();
    chk("post_rst_v", 64'(out_valid), 64'd0);

    // r0 destination, NOP and unused fields never hazard
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = mk(OP_I, 6'd0, 6'd0, 6'd0, 8'h05);
    #1 chk("r0_rdy", 64'(in_ready), 64'd1);
    step();
    chk("r0_we",   64'(out_we),  64'd0);
    chk("r0_imm",  64'(out_imm), 64'h05);
    chk("r0_busy", busy_map,     64'h0);
    in_instr = mk(OP_NOP, 6'd3, 6'd4, 6'd5, 8'h00);
    #1 chk("nop_rdy", 64'(in_ready), 64'd1);
    step();
    chk("nop_we",   64'(out_we), 64'd0);
    chk("nop_op",   64'(out_op), 64'h05);
    chk("nop_ra1",  64'(ra1),    64'd4);
    chk("nop_busy", busy_map,    64'h0);
    in_instr = mk(OP_R, 6'd8, 6'd1, 6'd1, 8'h00);
    step();
    chk("r8_busy", busy_map, 64'h100);
    in_instr = mk(6'h00, 6'd0, 6'd8, 6'd8, 8'h00);
    #1 chk("nop8_rdy", 64'(in_ready), 64'd1);
    step();
    in_instr = mk(OP_I, 6'd10, 6'd1, 6'd8, 8'h00);
    #1 chk("irs2_rdy", 64'(in_ready), 64'd1);
    step();
    chk("i10_busy", busy_map, 64'h500);
    in_instr = mk(OP_S, 6'd8, 6'd1, 6'd2, 8'h00);
    #1 chk("srd_rdy", 64'(in_ready), 64'd1);
    step();
    chk("s_busy", busy_map, 64'h500);
    in_instr = mk(OP_I, 6'd11, 6'd8, 6'd0, 8'h00);
    #1 chk("irs1_haz", 64'(in_ready), 64'd0);
    in_instr = mk(OP_R, 6'd10, 6'd1, 6'd2, 8'h00);
    #1 chk("waw_haz", 64'(in_ready), 64'd0);
    chk("sat_start", 64'(stall_cnt), 64'd0);

    // stall counter saturation
    repeat (65534) @(posedge clk);
    #1 chk("sat_pre", 64'(stall_cnt), 64'd65534);
    repeat (70000 - 65534) @(posedge clk);
    #1 chk("sat_hold", 64'(stall_cnt), 64'hFFFF);
    chk("sat_rdy", 64'(in_ready), 64'd0);
    in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
